// File: rtl/sv_alu_ga_rtl_pkg.sv
// Shared types and constants for the GA-driven ALU stimulus generator.
package sv_alu_ga_rtl_pkg;

  localparam int CUM_W = 12;

  localparam int GENE_OP0    = 0;
  localparam int GENE_MV0    = 16;
  localparam int GENE_CL0    = 19;
  localparam int GENE_LEN_LO = 22;
  localparam int GENE_LEN_HI = 23;
  localparam int PREP_LAST   = 21;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    MOVI_REG = 2'd0,
    MOVI_MEM = 2'd1,
    MOVI_IMM = 2'd2
  } movi_e;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_ONES = 2'd1,
    CLS_RAND = 2'd2
  } class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_G0,
    ST_G1,
    ST_G2,
    ST_OUT,
    ST_FIN
  } state_e;

  // Right-shifting Galois step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/alu_ga_weighted_pick.sv
// Weighted pick: scales a 16-bit random value onto the weight total and
// returns the first bucket whose cumulative sum exceeds it.
module alu_ga_weighted_pick
  import sv_alu_ga_rtl_pkg::*;
#(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0][CUM_W-1:0] cum,
  input  logic [CUM_W-1:0]        total,
  input  logic [15:0]             r16,
  output logic [IW-1:0]           idx
);

  logic [CUM_W+15:0] prod;
  logic [CUM_W-1:0]  s;

  assign prod = (CUM_W+16)'(r16) * (CUM_W+16)'(total);
  assign s    = prod[CUM_W+15:16];

  // Scanning downwards leaves the smallest matching index; zero weights
  // repeat the previous sum so they can never be the first match.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (s < cum[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/alu_ga_stim_gen.sv
// Chromosome-driven ALU stimulus generator: gene registers, LFSR,
// burst FSM and the valid/ready transaction output.
//
// state | meaning
// IDLE  | waiting for start, genes writable
// PREP  | one gene per cycle into cumulative sums
// G0    | pick opcode and operand select
// G1    | pick operand classes
// G2    | build operands, load output registers
// OUT   | tx_vld high until handshake
// FIN   | done pulse, genes writable, start accepted
module alu_ga_stim_gen
  import sv_alu_ga_rtl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OP_NUM     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_vld,
  input  logic [4:0]            cfg_addr,
  input  logic [7:0]            cfg_data,
  input  logic [31:0]           seed,
  input  logic                  start,
  output logic                  tx_vld,
  input  logic                  tx_rdy,
  output logic [3:0]            tx_op,
  output logic [1:0]            tx_movi,
  output logic [DATA_WIDTH-1:0] tx_reg_a,
  output logic [DATA_WIDTH-1:0] tx_mem,
  output logic [DATA_WIDTH-1:0] tx_imm,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           tx_cnt
);

  state_e state, state_nx;

  logic [7:0]  op_w [OP_NUM];
  logic [7:0]  mv_w [3];
  logic [7:0]  cl_w [3];
  logic [15:0] burst_len;

  logic [OP_NUM-1:0][CUM_W-1:0] cum_op;
  logic [2:0][CUM_W-1:0]        cum_mv;
  logic [2:0][CUM_W-1:0]        cum_cl;
  logic [2:0][CUM_W-1:0]        hi_cum;
  logic [CUM_W-1:0]             prep_sum;

  logic [4:0]  prep_idx;
  logic [31:0] lfsr;
  logic [3:0]  op_sel;
  movi_e       mv_sel;
  class_e      cls_a;
  class_e      cls_b;

  logic [3:0]  op_pick;
  logic [1:0]  lo_pick;
  logic [1:0]  hi_pick;
  logic        gene_wr_ok;
  logic [DATA_WIDTH-1:0] opnd_a;
  logic [DATA_WIDTH-1:0] opnd_b;

  function automatic logic [CUM_W-1:0] ext8(input logic [7:0] v);
    return CUM_W'(v);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] operand(input class_e c,
                                                    input logic [DATA_WIDTH-1:0] rnd);
    case (c)
      CLS_ZERO: return '0;
      CLS_ONES: return '1;
      default:  return rnd;
    endcase
  endfunction

  assign gene_wr_ok = (state == ST_IDLE) || (state == ST_FIN);

  // The high-half picker serves operand select in G0 and class B in G1.
  assign hi_cum = (state == ST_G1) ? cum_cl : cum_mv;

  alu_ga_weighted_pick #(.N(OP_NUM)) u_pick_op (
    .cum   (cum_op),
    .total (cum_op[OP_NUM-1]),
    .r16   (lfsr[15:0]),
    .idx   (op_pick)
  );

  alu_ga_weighted_pick #(.N(3)) u_pick_lo (
    .cum   (cum_cl),
    .total (cum_cl[2]),
    .r16   (lfsr[15:0]),
    .idx   (lo_pick)
  );

  alu_ga_weighted_pick #(.N(3)) u_pick_hi (
    .cum   (hi_cum),
    .total (hi_cum[2]),
    .r16   (lfsr[31:16]),
    .idx   (hi_pick)
  );

  assign opnd_a = operand(cls_a, lfsr[DATA_WIDTH-1:0]);
  assign opnd_b = operand(cls_b, lfsr[31:32-DATA_WIDTH]);

  always_comb begin
    prep_sum = '0;
    case (prep_idx)
      5'd16:   prep_sum = ext8(mv_w[0]);
      5'd17:   prep_sum = cum_mv[0] + ext8(mv_w[1]);
      5'd18:   prep_sum = cum_mv[1] + ext8(mv_w[2]);
      5'd19:   prep_sum = ext8(cl_w[0]);
      5'd20:   prep_sum = cum_cl[0] + ext8(cl_w[1]);
      5'd21:   prep_sum = cum_cl[1] + ext8(cl_w[2]);
      default: prep_sum = ext8(op_w[prep_idx[3:0]]) +
                          ((prep_idx[3:0] == 4'd0) ? '0 : cum_op[prep_idx[3:0] - 4'd1]);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OP_NUM; i++) op_w[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        mv_w[i] <= '0;
        cl_w[i] <= '0;
      end
      burst_len <= '0;
    end else if (cfg_vld && gene_wr_ok) begin
      case (cfg_addr)
        5'd16: mv_w[0] <= cfg_data;
        5'd17: mv_w[1] <= cfg_data;
        5'd18: mv_w[2] <= cfg_data;
        5'd19: cl_w[0] <= cfg_data;
        5'd20: cl_w[1] <= cfg_data;
        5'd21: cl_w[2] <= cfg_data;
        5'd22: burst_len[7:0]  <= cfg_data;
        5'd23: burst_len[15:8] <= cfg_data;
        default: if (!cfg_addr[4]) op_w[cfg_addr[3:0]] <= cfg_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_vld   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_PREP;
      ST_PREP: begin
        busy = 1'b1;
        if (prep_idx == 5'(PREP_LAST))
          state_nx = (burst_len == 16'd0) ? ST_FIN : ST_G0;
      end
      ST_G0: begin
        busy     = 1'b1;
        state_nx = ST_G1;
      end
      ST_G1: begin
        busy     = 1'b1;
        state_nx = ST_G2;
      end
      ST_G2: begin
        busy     = 1'b1;
        state_nx = ST_OUT;
      end
      ST_OUT: begin
        busy   = 1'b1;
        tx_vld = 1'b1;
        if (tx_rdy)
          state_nx = ((tx_cnt + 16'd1) == burst_len) ? ST_FIN : ST_G0;
      end
      ST_FIN: begin
        done     = 1'b1;
        state_nx = start ? ST_PREP : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= 32'd1;
      prep_idx <= '0;
      cum_op   <= '0;
      cum_mv   <= '0;
      cum_cl   <= '0;
      op_sel   <= '0;
      mv_sel   <= MOVI_REG;
      cls_a    <= CLS_ZERO;
      cls_b    <= CLS_ZERO;
      tx_op    <= '0;
      tx_movi  <= '0;
      tx_reg_a <= '0;
      tx_mem   <= '0;
      tx_imm   <= '0;
      tx_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_FIN: begin
          if (start) begin
            lfsr     <= (seed == 32'd0) ? 32'd1 : seed;
            tx_cnt   <= '0;
            prep_idx <= '0;
          end
        end
        ST_PREP: begin
          case (prep_idx)
            5'd16:   cum_mv[0] <= prep_sum;
            5'd17:   cum_mv[1] <= prep_sum;
            5'd18:   cum_mv[2] <= prep_sum;
            5'd19:   cum_cl[0] <= prep_sum;
            5'd20:   cum_cl[1] <= prep_sum;
            5'd21:   cum_cl[2] <= prep_sum;
            default: if (!prep_idx[4]) cum_op[prep_idx[3:0]] <= prep_sum;
          endcase
          prep_idx <= prep_idx + 5'd1;
        end
        ST_G0: begin
          op_sel <= op_pick;
          mv_sel <= movi_e'(hi_pick);
          lfsr   <= lfsr_step(lfsr);
        end
        ST_G1: begin
          cls_a <= class_e'(lo_pick);
          cls_b <= class_e'(hi_pick);
          lfsr  <= lfsr_step(lfsr);
        end
        ST_G2: begin
          tx_op    <= op_sel;
          tx_movi  <= mv_sel;
          tx_reg_a <= opnd_a;
          tx_mem   <= (mv_sel == MOVI_MEM) ? opnd_b : '0;
          tx_imm   <= (mv_sel == MOVI_IMM) ? opnd_b : '0;
          lfsr     <= lfsr_step(lfsr);
        end
        ST_OUT: if (tx_rdy) tx_cnt <= tx_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
